// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV64I core: sequences ALU, unified memory port,
// register file and PC/IR across fetch, decode, execute, memory and writeback.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpAluR   = 5'b01100;
  localparam logic [4:0] OpAluI   = 5'b00100;

  typedef enum logic [3:0] {
    StRst      = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StExecI    = 4'd8,
    StAluWb    = 4'd9,
    StBranch   = 4'd10,
    StTrap     = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retire_q;
  logic             retire;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 1'b0;

    case (state_q)
      StRst: state_d = StFetch;

      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // ALU computes PC+4 while the fetched word lands in IR
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = StDecode;
        end
      end

      StDecode: begin
        // ALUOut captures old_pc + imm as a speculative branch target
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAddr;
          OpAluR:          state_d = StExecR;
          OpAluI:          state_d = StExecI;
          OpBranch:        state_d = StBranch;
          default:         state_d = StTrap;
        endcase
      end

      StMemAddr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end

      StMemRead: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          mdr_write = 1'b1;
          state_d   = StMemWb;
        end
      end

      StMemWb: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end

      StMemWrite: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end

      StExecR: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end

      StExecI: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = StAluWb;
      end

      StAluWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end

      StBranch: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
        pc_src    = branch_taken;
        retire    = 1'b1;
        state_d   = StFetch;
      end

      StTrap: state_d = StTrap;

      default: state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRst;
      illegal_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  assign illegal      = illegal_q;
  assign state        = state_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table, randomized
// instruction stream against a timeline model, plus trap / wrap / async-reset sequences.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    opcode = 5'd0;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src;
  logic [1:0]    alu_src_a, alu_src_b, alu_op;
  logic          reg_write, wb_sel, illegal;
  logic [3:0]    state;
  logic [CW-1:0] retire_count;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .iord         (iord),
    .ir_write     (ir_write),
    .mdr_write    (mdr_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .state        (state),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_retire = 0;

  typedef struct {
    logic [4:0]  op;
    int          fw;
    int          mw;
    logic        bt;
    int          exp_len;
    logic [31:0] exp_trace;
    int          exp_regw;
    int          exp_pcw;
    int          exp_mdr;
  } vec_t;

  vec_t       tbl[7];
  logic [4:0] ops[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] outvec();
    return {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src, reg_write,
            wb_sel, illegal, alu_src_a, alu_src_b, alu_op};
  endfunction

  // Expected outputs at cycle c of an instruction, from its phase timeline:
  // fetch occupies cycles 0..fw, decode fw+1, execute/address fw+2, memory from fw+3.
  function automatic logic [15:0] exp_vec(input logic [4:0] op, input int fw, input int mw,
                                          input logic bt, input int c);
    logic ld, st, br, ar, ai, in_mem;
    logic req, we, io, irw, mdr, pcw, pcs, rw, wbs;
    logic [1:0] a, b, aop;
    ld = (op == 5'b00000); st = (op == 5'b01000); br = (op == 5'b11000);
    ar = (op == 5'b01100); ai = (op == 5'b00100);
    in_mem = (ld || st) && (c >= fw + 3) && (c <= fw + 3 + mw);
    {req, we, io, irw, mdr, pcw, pcs, rw, wbs} = '0;
    a = 2'd0; b = 2'd0; aop = 2'd0;
    if (c <= fw) req = 1'b1;
    if (c == fw) begin irw = 1'b1; pcw = 1'b1; b = 2'd1; end
    if (c == fw + 1) begin a = 2'd2; b = 2'd2; end
    if (c == fw + 2) begin
      if (ld || st) begin a = 2'd1; b = 2'd2; end
      if (ar) begin a = 2'd1; b = 2'd0; aop = 2'd2; end
      if (ai) begin a = 2'd1; b = 2'd2; aop = 2'd3; end
      if (br) begin a = 2'd1; b = 2'd0; aop = 2'd1; pcw = bt; pcs = bt; end
    end
    if (in_mem) begin req = 1'b1; io = 1'b1; we = st; end
    if (ld && c == fw + 3 + mw) mdr = 1'b1;
    if ((ar || ai) && c == fw + 3) rw = 1'b1;
    if (ld && c == fw + 4 + mw) begin rw = 1'b1; wbs = 1'b1; end
    return {req, we, io, irw, mdr, pcw, pcs, rw, wbs, 1'b0, a, b, aop};
  endfunction

  function automatic int exp_len(input logic [4:0] op, input int fw, input int mw);
    case (op)
      5'b00000: return fw + mw + 5;
      5'b01000: return fw + mw + 4;
      5'b01100, 5'b00100: return fw + 4;
      5'b11000: return fw + 3;
      default: return fw + 2;
    endcase
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return op inside {5'b00000, 5'b01000, 5'b11000, 5'b01100, 5'b00100};
  endfunction

  // Runs one instruction starting at a negedge in FETCH; returns at the negedge
  // after the FSM is back in FETCH (or has entered TRAP).
  task automatic run_instr(input logic [4:0] op, input int fw, input int mw, input logic bt,
                           output int len, output logic [31:0] trace, output int regw,
                           output int pcw, output int mdr);
    int c = 0;
    logic [3:0] prev;
    logic ldst, done;
    ldst = (op == 5'b00000) || (op == 5'b01000);
    done = 1'b0;
    trace = '0; regw = 0; pcw = 0; mdr = 0;
    while (!done) begin
      opcode = op;
      if (c <= fw) mem_ready = (c == fw);
      else if (ldst && c >= fw + 3 && c <= fw + 3 + mw) mem_ready = (c == fw + 3 + mw);
      else mem_ready = 1'($urandom_range(1, 0));
      branch_taken = (op == 5'b11000 && c == fw + 2) ? bt : 1'($urandom_range(1, 0));
      #1;
      check("outputs", 32'(outvec()), 32'(exp_vec(op, fw, mw, bt, c)));
      trace = {trace[27:0], state};
      if (reg_write) regw++;
      if (pc_write) pcw++;
      if (mdr_write) mdr++;
      prev = state;
      @(posedge clk);
      @(negedge clk);
      c++;
      if ((state == 4'd1 && prev != 4'd1) || state == 4'd15) begin
        done = 1'b1;
      end else if (c >= 60) begin
        check("instr_timeout", 32'(c), 32'(exp_len(op, fw, mw)));
        done = 1'b1;
      end
    end
    len = c;
    if (is_legal(op)) exp_retire = (exp_retire + 1) % (1 << CW);
    check("retire_count", 32'(retire_count), 32'(exp_retire));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outputs", 32'(outvec()), 32'd0);
    check("reset_count", 32'(retire_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_retire = 0;
    @(posedge clk);
    @(negedge clk);
    check("first_fetch", 32'(state), 32'd1);
  endtask

  int          len, regw, pcw, mdr, fw, mw;
  logic [31:0] trace;
  logic [4:0]  op;
  logic        bt;

  initial begin
    tbl[0] = '{5'b01100, 0, 0, 1'b0, 4,  32'h0000_1279, 1, 1, 0};
    tbl[1] = '{5'b00000, 2, 3, 1'b0, 10, 32'h1234_4445, 1, 1, 1};
    tbl[2] = '{5'b01000, 0, 0, 1'b0, 4,  32'h0000_1236, 0, 1, 0};
    tbl[3] = '{5'b11000, 0, 0, 1'b1, 3,  32'h0000_012A, 0, 2, 0};
    tbl[4] = '{5'b11000, 0, 0, 1'b0, 3,  32'h0000_012A, 0, 1, 0};
    tbl[5] = '{5'b00100, 1, 0, 1'b0, 5,  32'h0001_1289, 1, 1, 0};
    tbl[6] = '{5'b01000, 0, 2, 1'b0, 6,  32'h0012_3666, 0, 1, 0};
    ops[0] = 5'b00000; ops[1] = 5'b01000; ops[2] = 5'b11000;
    ops[3] = 5'b01100; ops[4] = 5'b00100;

    do_reset();

    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].bt, len, trace, regw, pcw, mdr);
      check("tbl_len", 32'(len), 32'(tbl[i].exp_len));
      check("tbl_trace", trace, tbl[i].exp_trace);
      check("tbl_reg_write", 32'(regw), 32'(tbl[i].exp_regw));
      check("tbl_pc_write", 32'(pcw), 32'(tbl[i].exp_pcw));
      check("tbl_mdr_write", 32'(mdr), 32'(tbl[i].exp_mdr));
    end
    check("tbl_retired", 32'(retire_count), 32'd7);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(4, 0)];
      fw = int'($urandom_range(2, 0));
      mw = int'($urandom_range(2, 0));
      bt = 1'($urandom_range(1, 0));
      run_instr(op, fw, mw, bt, len, trace, regw, pcw, mdr);
      check("rand_len", 32'(len), 32'(exp_len(op, fw, mw)));
    end

    // Illegal opcode: trap after decode, sticky until async reset.
    do_reset();
    run_instr(5'b11111, 0, 0, 1'b0, len, trace, regw, pcw, mdr);
    check("trap_len", 32'(len), 32'd2);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(1, 0));
      branch_taken = 1'($urandom_range(1, 0));
      opcode = 5'($urandom);
      #1;
      check("trap_hold", {12'd0, state, outvec()}, 32'h000F_0040);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("trap_async_state", 32'(state), 32'd0);
    check("trap_async_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retire = 0;
    @(posedge clk);
    @(negedge clk);

    // 17 I-ALU ops with a 4-bit counter wrap back to 1.
    for (int i = 0; i < 17; i++) begin
      run_instr(5'b00100, 0, 0, 1'b0, len, trace, regw, pcw, mdr);
    end
    check("wrap_count", 32'(retire_count), 32'd1);

    // Async reset while a fetch is stalled.
    mem_ready = 1'b0;
    #1;
    check("stall_mem_req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_outputs", 32'(outvec()), 32'd0);
    check("abort_count", 32'(retire_count), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV64I core variant. It sequences the shared ALU, the unified memory port, the register file and the PC/IR registers across fetch, decode, execute, memory and writeback. The immediate generator is driven straight from the IR opcode field. This block only picks whether the immediate reaches the ALU. Supported opcode classes are load, store, branch, R-type ALU and I-type ALU; anything else traps.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  5  IR bits [6:2]: 00000 load, 01000 store, 11000 branch, 01100 R-ALU, 00100 I-ALU
- branch_taken  in  1  ALU compare result, valid in BRANCH
- mem_ready  in  1  memory completes the request in this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load MDR from memory read data
- pc_write  out  1  PC update enable
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- alu_src_a  out  2  00 PC, 01 rs1, 10 old_pc
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- alu_op  out  2  00 add, 01 compare, 10 R-funct, 11 I-funct
- reg_write  out  1  register file write enable
- wb_sel  out  1  0 = ALUOut, 1 = MDR
- illegal  out  1  sticky trap flag
- state  out  4  current state encoding, for debug
- retire_count  out  CNT_W  instructions retired

## Operation
- State encodings: RST=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXEC_R=7, EXEC_I=8, ALUWB=9, BRANCH=10, TRAP=15. All other values are unreachable; if reached, next state is TRAP.
- Control outputs are combinational from state, mem_ready and branch_taken. Any output not listed for a state is 0.
- RST: all outputs 0. Next state is FETCH.
- FETCH:
  - Drives mem_req=1, iord=0, mem_we=0.
  - While mem_ready=0, stays in FETCH.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, alu_src_a=00, alu_src_b=01, alu_op=00. Next state is DECODE.
- DECODE:
  - Drives alu_src_a=10, alu_src_b=10, alu_op=00, so ALUOut = branch target.
  - Next state by opcode: 00000 or 01000 → MEMADDR; 01100 → EXEC_R; 00100 → EXEC_I; 11000 → BRANCH; other → TRAP.
- MEMADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next state is MEMREAD if opcode=00000, otherwise MEMWRITE.
- MEMREAD: mem_req=1, iord=1. Holds until mem_ready; in the ready cycle drives mdr_write=1. Next state is MEMWB.
- MEMWB: reg_write=1, wb_sel=1. Next state is FETCH; retire.
- MEMWRITE: mem_req=1, mem_we=1, iord=1. Holds until mem_ready. Next state is FETCH; retire in the ready cycle.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10. Next state is ALUWB.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=11. Next state is ALUWB.
- ALUWB: reg_write=1, wb_sel=0. Next state is FETCH; retire.
- BRANCH:
  - Drives alu_src_a=01, alu_src_b=00, alu_op=01.
  - If branch_taken=1: pc_write=1, pc_src=1.
  - Next state is FETCH; retire.
- TRAP:
  - illegal is set and held at 1.
  - All enables (mem_req, pc_write, ir_write, mdr_write, reg_write) are 0.
  - Stays in TRAP until rst_n is asserted.
- Retire: retire_count increments by 1 and wraps modulo 2^CNT_W.

## Timing
- Reset:
  - Asserting rst_n low forces state=RST, illegal=0, retire_count=0 immediately, regardless of the clock.
  - All outputs are 0 while in reset.
  - The first FETCH is the first rising edge after rst_n deasserts.
- Reset mid-memory-request: mem_req drops asynchronously. No write enable is asserted on the abandoned access.
- Memory handshake:
  - While a request is pending, mem_req, mem_we and iord are stable.
  - The access completes only in a cycle where mem_req=1 and mem_ready=1.
  - mem_ready is ignored when mem_req=0.
- Minimum latency with zero-wait memory: load 5 cycles, store 4, R/I-ALU 4, branch 3. Each memory wait cycle adds 1.
- retire_count updates on the clock edge ending the retiring cycle.
- branch_taken is sampled only in BRANCH.
- opcode is sampled only in DECODE and MEMADDR. The IR is stable there because ir_write is 0.

## Test plan
- Reset release, then R-type (opcode 01100) with mem_ready held at 1 → state sequence 1,2,7,9,1. reg_write=1 only in cycle 4. retire_count=1.
- Load (00000) with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total. mdr_write is a single-cycle pulse. wb_sel=1 with reg_write in MEMWB.
- Store (01000) with zero-wait memory → mem_we=1 and iord=1 only in MEMWRITE. reg_write never asserts. Returns to FETCH after 4 cycles.
- Branch (11000) run twice, with branch_taken=1 then 0 → pc_write=1 and pc_src=1 in BRANCH for the first run only. 3 cycles each. retire_count=2.
- Opcode 11111 → TRAP after DECODE. illegal=1 and all enables 0 for 20 cycles. rst_n low clears illegal and sets state=0 with no clock.
- With CNT_W=4, retire 17 I-ALU ops (00100) → retire_count=1 (wrap). rst_n pulsed mid-FETCH with mem_ready=0 → mem_req=0 asynchronously, count cleared.
